// File: rtl/gmii_rx_frame_checker.sv
// gmii_rx_frame_checker
// Receive-side GMII frame checker that sits behind the SGMII PCS. It strips the
// preamble and SFD, forwards frame bytes starting at DA, and runs a reflected
// CRC-32 check and a DA..FCS length check on every frame. At the end of each
// frame it emits one status strobe and bumps either the good or the bad
// frame counter.
//
// Build option: define FCS_STRIP_EN to hold back the last four bytes of each
// frame in a delay line so the FCS is never forwarded. Without the macro every
// byte is forwarded, FCS included, one cycle after its enabled sample.
//
// Error code bits: [0] crc, [1] short, [2] long, [3] rxer, [4] sfd.

module gmii_rx_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Cke,
    input  logic [7:0]  i8_RxD,
    input  logic        i_RxDV,
    input  logic        i_RxER,
    output logic [7:0]  o8_Data,
    output logic        o_Valid,
    output logic        o_Sof,
    output logic        o_Eof,
    output logic        o_Err,
    output logic [4:0]  o5_ErrCode,
    output logic [31:0] o32_GoodFrames,
    output logic [31:0] o32_BadFrames
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } state_t;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [10:0] LEN_SAT       = 11'h7FF;
    localparam logic [10:0] MIN_LEN_C     = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C     = 11'(MAX_LEN);
    localparam logic [7:0]  BYTE_PRE      = 8'h55;
    localparam logic [7:0]  BYTE_SFD      = 8'hD5;

    // Registered copies of the GMII inputs; all decisions use these.
    logic        cke_q,  cke_d;
    logic [7:0]  rxd_q,  rxd_d;
    logic        rxdv_q, rxdv_d;
    logic        rxer_q, rxer_d;

    // Frame tracking state.
    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] len_q, len_d;
    logic        flag_sfd_q, flag_sfd_d;
    logic        flag_rxer_q, flag_rxer_d;
    logic        first_q, first_d;

    // Registered outputs.
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        err_q, err_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] good_q, good_d;
    logic [31:0] bad_q, bad_d;

`ifdef FCS_STRIP_EN
    // Four-byte hold-back line; byte 3 is the oldest.
    logic [31:0] dly_q, dly_d;
    logic [2:0]  dly_cnt_q, dly_cnt_d;
`endif

    // One byte of the reflected (LSB-first) CRC-32 update.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Next-state logic: input capture, frame FSM, CRC/length tracking and output formation.
    always_comb begin
        logic [4:0] end_code;
        logic       end_frame;

        end_code    = 5'b00000;
        end_frame   = 1'b0;

        cke_d       = i_Cke;
        rxd_d       = i8_RxD;
        rxdv_d      = i_RxDV;
        rxer_d      = i_RxER;

        state_d     = state_q;
        crc_d       = crc_q;
        len_d       = len_q;
        flag_sfd_d  = flag_sfd_q;
        flag_rxer_d = flag_rxer_q;
        first_d     = first_q;

        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        err_d       = err_q;
        code_d      = code_q;
        good_d      = good_q;
        bad_d       = bad_q;

`ifdef FCS_STRIP_EN
        dly_d       = dly_q;
        dly_cnt_d   = dly_cnt_q;
`endif

        if (cke_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (rxdv_q) begin
                        crc_d       = CRC_INIT;
                        len_d       = 11'd0;
                        flag_sfd_d  = 1'b0;
                        flag_rxer_d = 1'b0;
                        first_d     = 1'b1;
`ifdef FCS_STRIP_EN
                        dly_cnt_d   = 3'd0;
`endif
                        if (rxd_q == BYTE_PRE) begin
                            state_d = ST_PRE;
                        end else begin
                            state_d    = ST_DROP;
                            flag_sfd_d = 1'b1;
                        end
                    end
                end

                ST_PRE: begin
                    if (!rxdv_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (rxer_q) begin
                            flag_rxer_d = 1'b1;
                        end
                        if (rxd_q == BYTE_SFD) begin
                            state_d = ST_DATA;
                        end else if (rxd_q != BYTE_PRE) begin
                            state_d    = ST_DROP;
                            flag_sfd_d = 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (rxdv_q) begin
                        if (rxer_q) begin
                            flag_rxer_d = 1'b1;
                        end
                        crc_d = crc_next(crc_q, rxd_q);
                        if (len_q != LEN_SAT) begin
                            len_d = len_q + 11'd1;
                        end
`ifdef FCS_STRIP_EN
                        dly_d = {dly_q[23:0], rxd_q};
                        if (dly_cnt_q == 3'd4) begin
                            data_d  = dly_q[31:24];
                            valid_d = 1'b1;
                            sof_d   = first_q;
                            first_d = 1'b0;
                        end else begin
                            dly_cnt_d = dly_cnt_q + 3'd1;
                        end
`else
                        data_d  = rxd_q;
                        valid_d = 1'b1;
                        sof_d   = first_q;
                        first_d = 1'b0;
`endif
                    end else begin
                        end_frame = 1'b1;
                        end_code  = {flag_sfd_q, flag_rxer_q,
                                     (len_q > MAX_LEN_C),
                                     (len_q < MIN_LEN_C),
                                     (crc_q != CRC_RESIDUE)};
                    end
                end

                ST_DROP: begin
                    if (rxdv_q) begin
                        if (rxer_q) begin
                            flag_rxer_d = 1'b1;
                        end
                    end else begin
                        end_frame = 1'b1;
                        end_code  = {flag_sfd_q, flag_rxer_q, 3'b000};
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (end_frame) begin
                state_d = ST_IDLE;
                eof_d   = 1'b1;
                code_d  = end_code;
                err_d   = |end_code;
                if (|end_code) begin
                    bad_d = bad_q + 32'd1;
                end else begin
                    good_d = good_q + 32'd1;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cke_q       <= 1'b0;
            rxd_q       <= 8'h00;
            rxdv_q      <= 1'b0;
            rxer_q      <= 1'b0;
            state_q     <= ST_IDLE;
            crc_q       <= CRC_INIT;
            len_q       <= 11'd0;
            flag_sfd_q  <= 1'b0;
            flag_rxer_q <= 1'b0;
            first_q     <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 5'b00000;
            good_q      <= 32'd0;
            bad_q       <= 32'd0;
`ifdef FCS_STRIP_EN
            dly_q       <= 32'd0;
            dly_cnt_q   <= 3'd0;
`endif
        end else begin
            cke_q       <= cke_d;
            rxd_q       <= rxd_d;
            rxdv_q      <= rxdv_d;
            rxer_q      <= rxer_d;
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            flag_sfd_q  <= flag_sfd_d;
            flag_rxer_q <= flag_rxer_d;
            first_q     <= first_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            err_q       <= err_d;
            code_q      <= code_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
`ifdef FCS_STRIP_EN
            dly_q       <= dly_d;
            dly_cnt_q   <= dly_cnt_d;
`endif
        end
    end

    assign o8_Data        = data_q;
    assign o_Valid        = valid_q;
    assign o_Sof          = sof_q;
    assign o_Eof          = eof_q;
    assign o_Err          = err_q;
    assign o5_ErrCode     = code_q;
    assign o32_GoodFrames = good_q;
    assign o32_BadFrames  = bad_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// tb_gmii_rx_frame_checker
// Directed bench for gmii_rx_frame_checker in its default build (FCS forwarded).
// Frames are built with a pattern payload plus an FCS generated here, driven as
// GMII samples, and the outputs are tallied by a negedge monitor.

module tb_gmii_rx_frame_checker;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_Cke;
    logic [7:0]  i8_RxD;
    logic        i_RxDV;
    logic        i_RxER;
    logic [7:0]  o8_Data;
    logic        o_Valid;
    logic        o_Sof;
    logic        o_Eof;
    logic        o_Err;
    logic [4:0]  o5_ErrCode;
    logic [31:0] o32_GoodFrames;
    logic [31:0] o32_BadFrames;

    gmii_rx_frame_checker dut (
        .i_Clk          (i_Clk),
        .i_Rst          (i_Rst),
        .i_Cke          (i_Cke),
        .i8_RxD         (i8_RxD),
        .i_RxDV         (i_RxDV),
        .i_RxER         (i_RxER),
        .o8_Data        (o8_Data),
        .o_Valid        (o_Valid),
        .o_Sof          (o_Sof),
        .o_Eof          (o_Eof),
        .o_Err          (o_Err),
        .o5_ErrCode     (o5_ErrCode),
        .o32_GoodFrames (o32_GoodFrames),
        .o32_BadFrames  (o32_BadFrames)
    );

    // 125 MHz GMII clock.
    always #4 i_Clk = ~i_Clk;

    int n_total = 0;
    int n_bad   = 0;

    // Monitor tallies, written only by the monitor process.
    int         valid_cnt   = 0;
    int         sof_cnt     = 0;
    int         eof_cnt     = 0;
    int         hold_viol   = 0;
    int         sof_orphan  = 0;
    int         eof_valid   = 0;
    logic [7:0] sof_byte    = 8'h00;
    logic       eof_err     = 1'b0;
    logic [4:0] eof_code    = 5'b00000;
    logic [7:0] prev_data   = 8'h00;
    logic [4:0] prev_code   = 5'b00000;

    // Baselines taken by the stimulus process before each step.
    int base_valid, base_sof, base_eof, base_hold;

    logic [7:0] frame [0:2047];
    int         frame_len;

    // Output monitor sampling away from the active edge.
    always @(negedge i_Clk) begin
        if (o_Valid) valid_cnt++;
        if (o_Sof) begin
            sof_cnt++;
            sof_byte = o8_Data;
            if (!o_Valid) sof_orphan++;
        end
        if (o_Eof) begin
            eof_cnt++;
            eof_err  = o_Err;
            eof_code = o5_ErrCode;
            if (o_Valid) eof_valid++;
        end
        if (!o_Valid && (o8_Data !== prev_data)) hold_viol++;
        if (!o_Eof && (o5_ErrCode !== prev_code)) hold_viol++;
        prev_data = o8_Data;
        prev_code = o5_ErrCode;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_total++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Builds a DA..FCS frame of total_len bytes with a valid FCS appended LSB first.
    task automatic buildFrame(input int total_len);
        logic [31:0] crc;
        int          n;
        n   = total_len - 4;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            frame[i] = 8'((i * 7 + 3) & 8'hFF);
            crc = crc ^ {24'h000000, frame[i]};
            for (int b = 0; b < 8; b++) begin
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
            end
        end
        crc = ~crc;
        frame[n]     = crc[7:0];
        frame[n + 1] = crc[15:8];
        frame[n + 2] = crc[23:16];
        frame[n + 3] = crc[31:24];
        frame_len = total_len;
    endtask

    // One GMII sample, held for pace clocks with i_Cke high only on the first.
    task automatic driveSample(input logic [7:0] d, input logic dv, input logic er, input int pace);
        i8_RxD = d;
        i_RxDV = dv;
        i_RxER = er;
        i_Cke  = 1'b1;
        @(posedge i_Clk);
        #1;
        for (int k = 1; k < pace; k++) begin
            i_Cke = 1'b0;
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic idleCycles(input int n);
        i_RxDV = 1'b0;
        i_RxER = 1'b0;
        i_Cke  = 1'b1;
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    // Preamble, SFD byte, the current frame, then gap idle samples.
    // er_idx marks the frame byte sent with RxER; abort_at pulses reset instead of that byte.
    task automatic applyStimulus(input int pace, input logic [7:0] sfd, input int er_idx,
                                 input int abort_at, input int gap);
        bit aborted;
        aborted = 1'b0;
        for (int i = 0; i < 7; i++) driveSample(8'h55, 1'b1, 1'b0, pace);
        driveSample(sfd, 1'b1, 1'b0, pace);
        for (int i = 0; i < frame_len && !aborted; i++) begin
            if (i == abort_at) begin
                i_Rst  = 1'b1;
                i_RxDV = 1'b0;
                i_Cke  = 1'b1;
                @(posedge i_Clk);
                #1;
                i_Rst   = 1'b0;
                aborted = 1'b1;
            end else begin
                driveSample(frame[i], 1'b1, (i == er_idx), pace);
            end
        end
        if (!aborted) begin
            for (int g = 0; g < gap; g++) driveSample(8'h00, 1'b0, 1'b0, pace);
        end
        i_Cke = 1'b1;
    endtask

    // Bounded wait for the monitor to see the given number of end strobes.
    task automatic waitEof(input int target);
        int budget;
        budget = 0;
        while (eof_cnt < target && budget < 400) begin
            @(posedge i_Clk);
            #1;
            budget++;
        end
        idleCycles(4);
    endtask

    task automatic snap();
        base_valid = valid_cnt;
        base_sof   = sof_cnt;
        base_eof   = eof_cnt;
        base_hold  = hold_viol;
    endtask

    initial begin
        i_Rst  = 1'b1;
        i_Cke  = 1'b1;
        i8_RxD = 8'h00;
        i_RxDV = 1'b0;
        i_RxER = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1;

        // Reset state.
        checkOutput("rst_valid", 64'(o_Valid), 64'd0);
        checkOutput("rst_eof",   64'(o_Eof), 64'd0);
        checkOutput("rst_err",   64'({o_Err, o5_ErrCode}), 64'd0);
        checkOutput("rst_good",  64'(o32_GoodFrames), 64'd0);
        checkOutput("rst_bad",   64'(o32_BadFrames), 64'd0);
        i_Rst = 1'b0;
        idleCycles(3);

        // Good 64-byte frame.
        $display("[TB] good frame");
        snap();
        buildFrame(64);
        applyStimulus(1, 8'hD5, -1, -1, 1);
        waitEof(base_eof + 1);
        checkOutput("good_valid_cnt", 64'(valid_cnt - base_valid), 64'd64);
        checkOutput("good_sof_cnt",   64'(sof_cnt - base_sof), 64'd1);
        checkOutput("good_sof_byte",  64'(sof_byte), 64'h03);
        checkOutput("good_eof_cnt",   64'(eof_cnt - base_eof), 64'd1);
        checkOutput("good_err",       64'(eof_err), 64'd0);
        checkOutput("good_code",      64'(eof_code), 64'd0);
        checkOutput("good_cnt",       64'(o32_GoodFrames), 64'd1);
        checkOutput("good_bad_cnt",   64'(o32_BadFrames), 64'd0);

        // Same frame, last FCS byte corrupted.
        $display("[TB] corrupted fcs");
        snap();
        frame[63] = frame[63] ^ 8'h01;
        applyStimulus(1, 8'hD5, -1, -1, 1);
        waitEof(base_eof + 1);
        checkOutput("crc_err",  64'(eof_err), 64'd1);
        checkOutput("crc_code", 64'(eof_code), 64'b00001);
        checkOutput("crc_bad",  64'(o32_BadFrames), 64'd1);

        // Short (40) and long (1600) frames with valid FCS.
        $display("[TB] short and long");
        snap();
        buildFrame(40);
        applyStimulus(1, 8'hD5, -1, -1, 1);
        waitEof(base_eof + 1);
        checkOutput("short_code", 64'(eof_code), 64'b00010);
        snap();
        buildFrame(1600);
        applyStimulus(1, 8'hD5, -1, -1, 1);
        waitEof(base_eof + 1);
        checkOutput("long_code",  64'(eof_code), 64'b00100);
        checkOutput("long_valid", 64'(valid_cnt - base_valid), 64'd1600);
        checkOutput("long_bad",   64'(o32_BadFrames), 64'd3);

        // Bad SFD: nothing forwarded, still reports.
        $display("[TB] bad sfd");
        snap();
        buildFrame(64);
        applyStimulus(1, 8'hD4, -1, -1, 1);
        waitEof(base_eof + 1);
        checkOutput("sfd_valid", 64'(valid_cnt - base_valid), 64'd0);
        checkOutput("sfd_eof",   64'(eof_cnt - base_eof), 64'd1);
        checkOutput("sfd_code",  64'(eof_code), 64'b10000);
        checkOutput("sfd_bad",   64'(o32_BadFrames), 64'd4);

        // RxER on data byte 20 of a good frame.
        $display("[TB] rxer");
        snap();
        applyStimulus(1, 8'hD5, 20, -1, 1);
        waitEof(base_eof + 1);
        checkOutput("rxer_code",  64'(eof_code), 64'b01000);
        checkOutput("rxer_valid", 64'(valid_cnt - base_valid), 64'd64);
        checkOutput("rxer_bad",   64'(o32_BadFrames), 64'd5);

        // 100M pacing, two good frames with one idle sample between.
        $display("[TB] paced back-to-back");
        snap();
        applyStimulus(10, 8'hD5, -1, -1, 1);
        applyStimulus(10, 8'hD5, -1, -1, 1);
        waitEof(base_eof + 2);
        checkOutput("pace_eof_cnt", 64'(eof_cnt - base_eof), 64'd2);
        checkOutput("pace_valid",   64'(valid_cnt - base_valid), 64'd128);
        checkOutput("pace_sof",     64'(sof_cnt - base_sof), 64'd2);
        checkOutput("pace_code",    64'(eof_code), 64'd0);
        checkOutput("pace_hold",    64'(hold_viol - base_hold), 64'd0);
        checkOutput("pace_good",    64'(o32_GoodFrames), 64'd3);

        // Reset at byte 30 discards the frame and clears the counters.
        $display("[TB] reset mid-frame");
        snap();
        applyStimulus(1, 8'hD5, -1, 30, 1);
        idleCycles(20);
        checkOutput("mid_rst_eof",  64'(eof_cnt - base_eof), 64'd0);
        checkOutput("mid_rst_good", 64'(o32_GoodFrames), 64'd0);
        checkOutput("mid_rst_bad",  64'(o32_BadFrames), 64'd0);
        snap();
        applyStimulus(1, 8'hD5, -1, -1, 1);
        waitEof(base_eof + 1);
        checkOutput("post_rst_good", 64'(o32_GoodFrames), 64'd1);
        checkOutput("post_rst_code", 64'(eof_code), 64'd0);

        // Framing rules over the whole run.
        checkOutput("sof_without_valid", 64'(sof_orphan), 64'd0);
        checkOutput("eof_with_valid",    64'(eof_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
